// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
// Glyphs are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic DP_OFF = 1'b1;

  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNS  = 2'd2,
    DIG_THOUS = 2'd3
  } digit_e;

  typedef struct packed {
    logic [3:0] thous;
    logic [3:0] huns;
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment glyph; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode display driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] THOUS,
  input  logic [3:0] HUNS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       UPD_DONE
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  digit_e        idx_q, idx_d;
  digits_t       disp_q, disp_d;
  digits_t       pbuf_q, pbuf_d;
  logic          pend_q, pend_d;
  logic          upd_q, upd_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  digits_t    din;
  logic       tick;
  logic       boundary;
  logic       blank;
  logic [3:0] nib;
  logic [6:0] glyph;

  assign din = {THOUS, HUNS, TENS, ONES};

  always_comb begin
    tick     = (cnt_q == CW'(REFRESH_DIV - 1));
    boundary = tick && (idx_q == DIG_THOUS);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? digit_e'(idx_q + 2'd1) : idx_q;
    disp_d   = disp_q;
    pbuf_d   = pbuf_q;
    pend_d   = pend_q;
    upd_d    = 1'b0;
    // A LOAD coinciding with the boundary bypasses the pending buffer entirely.
    if (boundary && LOAD) begin
      disp_d = din;
      pend_d = 1'b0;
      upd_d  = 1'b1;
    end else if (boundary && pend_q) begin
      disp_d = pbuf_q;
      pend_d = 1'b0;
      upd_d  = 1'b1;
    end else if (LOAD) begin
      pbuf_d = din;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    nib   = disp_q.ones;
    blank = 1'b0;
    case (idx_q)
      DIG_ONES:  nib = disp_q.ones;
      DIG_TENS:  nib = disp_q.tens;
      DIG_HUNS:  nib = disp_q.huns;
      DIG_THOUS: nib = disp_q.thous;
      default:   nib = disp_q.ones;
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (idx_q)
      DIG_THOUS: blank = (disp_q.thous == 4'd0);
      DIG_HUNS:  blank = (disp_q.thous == 4'd0) && (disp_q.huns == 4'd0);
      DIG_TENS:  blank = (disp_q.thous == 4'd0) && (disp_q.huns == 4'd0)
                         && (disp_q.tens == 4'd0);
      default:   blank = 1'b0;
    endcase
`endif
    an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank ? SEG_OFF : glyph;
  end

  seg7_decode u_decode (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q  <= '0;
      idx_q  <= DIG_ONES;
      disp_q <= '0;
      pbuf_q <= '0;
      pend_q <= 1'b0;
      upd_q  <= 1'b0;
      an_q   <= '1;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pbuf_q <= pbuf_d;
      pend_q <= pend_d;
      upd_q  <= upd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign AN       = an_q;
  assign SEG      = seg_q;
  assign DP       = DP_OFF;
  assign UPD_DONE = upd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed, table-driven bench for seg7_scan with REFRESH_DIV=4 (16-cycle frames).
module tb_seg7_scan;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] thous, huns, tens, ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       upd;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .LOAD     (load),
    .THOUS    (thous),
    .HUNS     (huns),
    .TENS     (tens),
    .ONES     (ones),
    .AN       (an),
    .SEG      (seg),
    .DP       (dp),
    .UPD_DONE (upd)
  );

  typedef struct {
    logic [3:0]      th, hu, te, on;
    logic [3:0][6:0] seg;    // expected glyph per slot, [0]=ones
    logic [3:0]      blank;  // slots blanked when leading-zero blanking is on
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] an_pat[4];
  int         checks = 0;
  int         errors = 0;
  int         k = 0;     // rising edges since reset release
  logic [3:0] prev_an3;
  logic [6:0] prev_seg3;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic step_to(input int r);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((k % 16) != r && n < 32);
  endtask

  task automatic set_in(input logic [3:0] a, b, c, d);
    thous = a; huns = b; tens = c; ones = d;
  endtask

  task automatic chk_slot(input string name, input int s, input logic [6:0] g, input logic bl);
    if (BLANK_EN && bl) begin
      chk({name, "_an"}, 16'(an), 16'(4'b1111));
      chk({name, "_seg"}, 16'(seg), 16'(7'b1111111));
    end else begin
      chk({name, "_an"}, 16'(an), 16'(an_pat[s]));
      chk({name, "_seg"}, 16'(seg), 16'(g));
    end
  endtask

  initial begin
    an_pat[0] = 4'b1110; an_pat[1] = 4'b1101;
    an_pat[2] = 4'b1011; an_pat[3] = 4'b0111;
    vecs[0] = '{4'h0, 4'h2, 4'h5, 4'h5,
                {7'b1000000, 7'b0100100, 7'b0010010, 7'b0010010}, 4'b1000};
    vecs[1] = '{4'h9, 4'h8, 4'h6, 4'h0,
                {7'b0010000, 7'b0000000, 7'b0000010, 7'b1000000}, 4'b0000};
    vecs[2] = '{4'h0, 4'h0, 4'hC, 4'h3,
                {7'b1000000, 7'b1000000, 7'b0111111, 7'b0110000}, 4'b1100};
    vecs[3] = '{4'h0, 4'h0, 4'h0, 4'h0,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1110};
    vecs[4] = '{4'hF, 4'hA, 4'h1, 4'h7,
                {7'b0111111, 7'b0111111, 7'b1111001, 7'b1111000}, 4'b0000};
    vecs[5] = '{4'h0, 4'h1, 4'h0, 4'h4,
                {7'b1000000, 7'b1111001, 7'b1000000, 7'b0011001}, 4'b1000};

    // Reset
    rst = 1'b0; load = 1'b0; set_in(4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    repeat (3) step();
    chk("rst_an", 16'(an), 16'(4'b1111));
    chk("rst_seg", 16'(seg), 16'(7'b1111111));
    chk("rst_dp", 16'(dp), 16'(1'b1));
    chk("rst_upd", 16'(upd), 16'(1'b0));
    rst = 1'b1; k = 0;
    step();
    chk("rel_an", 16'(an), 16'(4'b1110));
    chk("rel_seg", 16'(seg), 16'(7'b1000000));
    step_to(4);
    chk("hold_an", 16'(an), 16'(4'b1110));
    step();
    chk("adv_an", 16'(an), 16'(4'b1101));
    chk_slot("adv", 1, 7'b1000000, 1'b1);

    prev_an3  = BLANK_EN ? 4'b1111 : 4'b0111;
    prev_seg3 = BLANK_EN ? 7'b1111111 : 7'b1000000;

    // Mid-frame LOAD vectors
    for (int v = 0; v < 6; v++) begin
      step_to(5);
      load = 1'b1; set_in(vecs[v].th, vecs[v].hu, vecs[v].te, vecs[v].on);
      step();
      load = 1'b0; set_in(4'hE, 4'hE, 4'hE, 4'hE);
      step_to(13);
      chk("old_an", 16'(an), 16'(prev_an3));
      chk("old_seg", 16'(seg), 16'(prev_seg3));
      step_to(15);
      chk("pre_upd", 16'(upd), 16'(1'b0));
      step();
      chk("upd", 16'(upd), 16'(1'b1));
      for (int s = 0; s < 4; s++) begin
        step_to(1 + 4 * s);
        if (s == 0) chk("upd_pulse", 16'(upd), 16'(1'b0));
        chk_slot("vec", s, vecs[v].seg[s], vecs[v].blank[s]);
        chk("dp", 16'(dp), 16'(1'b1));
      end
      prev_an3  = (BLANK_EN && vecs[v].blank[3]) ? 4'b1111 : 4'b0111;
      prev_seg3 = (BLANK_EN && vecs[v].blank[3]) ? 7'b1111111 : vecs[v].seg[3];
    end

    // LOAD exactly on the frame-boundary cycle
    step_to(15);
    load = 1'b1; set_in(4'h1, 4'h2, 4'h3, 4'h4);
    step();
    load = 1'b0; set_in(4'hE, 4'hE, 4'hE, 4'hE);
    chk("bnd_upd", 16'(upd), 16'(1'b1));
    step();
    chk_slot("bnd_ones", 0, 7'b0011001, 1'b0);
    step_to(5);
    chk_slot("bnd_tens", 1, 7'b0110000, 1'b0);
    step_to(0);
    chk("bnd_noupd", 16'(upd), 16'(1'b0));

    // Two LOADs in one frame: last wins
    step_to(2);
    load = 1'b1; set_in(4'h9, 4'h9, 4'h9, 4'h9);
    step();
    load = 1'b0;
    step_to(9);
    load = 1'b1; set_in(4'h0, 4'h0, 4'h0, 4'h7);
    step();
    load = 1'b0; set_in(4'hE, 4'hE, 4'hE, 4'hE);
    step_to(0);
    chk("two_upd", 16'(upd), 16'(1'b1));
    step_to(1);
    chk_slot("two_ones", 0, 7'b1111000, 1'b0);
    step_to(5);
    chk_slot("two_tens", 1, 7'b1000000, 1'b1);
    step_to(9);
    chk_slot("two_huns", 2, 7'b1000000, 1'b1);
    step_to(13);
    chk_slot("two_thous", 3, 7'b1000000, 1'b1);

    // Reset mid-frame with LOAD pending; LOAD during reset ignored
    step_to(5);
    load = 1'b1; set_in(4'h3, 4'h3, 4'h3, 4'h3);
    step();
    load = 1'b0;
    step_to(9);
    rst = 1'b0; load = 1'b1; set_in(4'h6, 4'h6, 4'h6, 4'h6);
    step();
    chk("mrst_an", 16'(an), 16'(4'b1111));
    chk("mrst_seg", 16'(seg), 16'(7'b1111111));
    chk("mrst_upd", 16'(upd), 16'(1'b0));
    step();
    rst = 1'b1; load = 1'b0; set_in(4'hE, 4'hE, 4'hE, 4'hE); k = 0;
    step();
    chk_slot("mrel_ones", 0, 7'b1000000, 1'b0);
    step_to(5);
    chk_slot("mrel_tens", 1, 7'b1000000, 1'b1);
    step_to(0);
    chk("mrel_noupd", 16'(upd), 16'(1'b0));
    step();
    chk_slot("mrel_ones2", 0, 7'b1000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed four-digit seven-segment display driver that consumes the BCD digits produced by the binary-to-BCD converter (THOUS/HUNS/TENS/ONES) and drives the board's common-anode display. It double-buffers the digits so a new value takes effect only at a scan-frame boundary, which prevents a frame from mixing old and new digits. It scans one digit per refresh slot and decodes each nibble to an active-low segment pattern.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; minimum 2. One full frame lasts 4*REFRESH_DIV cycles.
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- LOAD  in  1  single-cycle strobe; samples THOUS/HUNS/TENS/ONES into the pending buffer
- THOUS  in  4  BCD thousands digit
- HUNS  in  4  BCD hundreds digit
- TENS  in  4  BCD tens digit
- ONES  in  4  BCD ones digit
- AN  out  4  active-low anode enables; AN[0]=ONES … AN[3]=THOUS
- SEG  out  7  active-low cathodes {g,f,e,d,c,b,a}
- DP  out  1  decimal point, active-low; constant 1 (off)
- UPD_DONE  out  1  one-cycle pulse when the pending buffer is copied to the display registers

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. The cycle at terminal count is the "slot tick".
- 2-bit digit index advances 0→1→2→3→0 on each slot tick. A slot tick with index 3 is the "frame boundary".
- LOAD copies the four inputs into the pending buffer and sets the pending flag. A later LOAD in the same frame overwrites the buffer, so the last LOAD wins.
- At a frame boundary with the pending flag set: the pending buffer is copied to the display registers, the flag is cleared, and UPD_DONE pulses in the same cycle.
- LOAD in the same cycle as a frame boundary: the inputs on that cycle go directly to the display registers. UPD_DONE pulses and the pending flag ends cleared.
- Decode:
  - Nibble 0–9 maps to standard glyphs, e.g. 0→1000000, 1→1111001, 8→0000000.
  - Nibble 10–15 maps to a dash (0111111).
- AN and SEG are registered from the index and the display registers. Exactly one AN bit is low per slot, unless that digit is blanked (see Configuration).
- Reset values: AN=1111, SEG=1111111, DP=1, UPD_DONE=0, prescaler=0, index=0, display registers=0, pending buffer=0, pending flag=0.

## Timing
- AN/SEG lag the index by one cycle.
- First rising edge after RST goes high drives AN=1110 and SEG=1000000.
- Each AN pattern is held exactly REFRESH_DIV cycles.
- LOAD-to-display latency:
  - Set by the next frame boundary, at most 4*REFRESH_DIV cycles.
  - The new digit 0 appears on AN/SEG one cycle after UPD_DONE.
- RST low at any time (including mid-frame or with LOAD pending) gives reset values on the next edge. Pending data is discarded.
- LOAD while RST is low is ignored.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - THOUS is blanked if it is 0.
  - HUNS is blanked if THOUS and HUNS are both 0.
  - TENS is blanked if THOUS, HUNS and TENS are all 0.
  - ONES is never blanked.
  - A blanked slot drives AN=1111 and SEG=1111111 for its full duration.
  - Blanking is evaluated on the display registers, not the inputs.
- SEG7_LEADING_ZERO_BLANK_EN undefined: all four digits are always shown, and zeros display as 0.

## Structure
- Shared package seg7_pkg holds:
  - NUM_DIGITS=4
  - active-low glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - DP_OFF
- Sub-module seg7_decode: purely combinational mapping of a 4-bit nibble to a 7-bit pattern; one instance on the selected digit.
- Top contains the prescaler, index, pending/display buffers, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold RST=0 for 3 cycles → AN=1111, SEG=1111111, DP=1. Release → next edge gives AN=1110, SEG=1000000; AN advances to 1101 after 4 cycles.
- Mid-frame LOAD {0,2,5,5} at index 1 → display unchanged until the frame boundary. UPD_DONE pulses at index-3 terminal count. The following slots show:
  - AN=1110 with SEG=0010010
  - AN=1101 with SEG=0010010
  - AN=1011 with SEG=0100100
  - AN=0111 with SEG=1000000, or AN=1111 with SEG=1111111 when the macro is defined
- LOAD {1,2,3,4} exactly on a frame-boundary cycle → UPD_DONE pulses the same cycle; the next slot shows AN=1110, SEG=0011001.
- Two LOADs in one frame, {9,9,9,9} then {0,0,0,7} → only 7 appears in the ONES slot after the boundary. Thousands, hundreds and tens slots are blanked with the macro, or show 0 without it.
- Nibble 4'hC on TENS → the tens slot shows SEG=0111111.
- RST low at index 2 with LOAD pending → reset values on the next edge. After release, the display shows 0 and UPD_DONE does not pulse at the next boundary.
